// File: rtl/dcache_pkg.sv
// Shared D-cache types, geometry constants and address helpers.
// Used by dcache_miss_ctrl (optional statistics via DCACHE_MISS_STATS_EN) and the cache unit.
package dcache_pkg;

    localparam int ADDR_W     = 32;
    localparam int BEAT_W     = 32;
    localparam int LINE_BEATS = 4;
    localparam int LINE_W     = LINE_BEATS * BEAT_W;
    localparam int LINE_BYTES = 16;
    localparam int OFFSET_W   = 4;
    localparam int INDEX_W    = 8;
    localparam int TAG_W      = 20;
    localparam int CNT_W      = 2;

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_BEATS - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_WB_RD,
        S_WB_CAP,
        S_WB_REQ,
        S_WB_DATA,
        S_RD_REQ,
        S_RD_DATA,
        S_REFILL,
        S_DONE
    } miss_state_e;

    function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
    endfunction

    function automatic logic [ADDR_W-1:0] wb_base(input logic [TAG_W-1:0]   tag,
                                                  input logic [INDEX_W-1:0] index);
        return {tag, index, {OFFSET_W{1'b0}}};
    endfunction

endpackage

// File: rtl/dcache_line_buf.sv
// One-line staging buffer with a wrapping beat counter: parallel load from the cache,
// beat-wise fill from memory reads and beat-wise drain towards memory writes.
module dcache_line_buf
    import dcache_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [LINE_W-1:0] line_i,
    input  logic              beat_wr_i,
    input  logic [BEAT_W-1:0] beat_i,
    input  logic              beat_rd_i,
    output logic [BEAT_W-1:0] beat_o,
    output logic [CNT_W-1:0]  cnt_o,
    output logic [LINE_W-1:0] line_o
);

    logic [LINE_W-1:0] line_q, line_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // The counter addresses the current beat for both directions and wraps back to 0 after the last one.
    always_comb begin
        line_d = line_q;
        cnt_d  = cnt_q;
        if (load_i) begin
            line_d = line_i;
        end
        if (beat_wr_i) begin
            line_d[int'(cnt_q) * BEAT_W +: BEAT_W] = beat_i;
        end
        if (beat_wr_i || beat_rd_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            line_q <= '0;
            cnt_q  <= '0;
        end else begin
            line_q <= line_d;
            cnt_q  <= cnt_d;
        end
    end

    assign beat_o = line_q[int'(cnt_q) * BEAT_W +: BEAT_W];
    assign cnt_o  = cnt_q;
    assign line_o = line_q;

endmodule

// File: rtl/dcache_miss_ctrl.sv
// D-cache miss handler: optional dirty-victim writeback, 4-beat line fetch, cache refill.
// Define DCACHE_MISS_STATS_EN to add the stat_miss_o / stat_wb_o event counters.
module dcache_miss_ctrl
    import dcache_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              miss_valid_i,
    output logic              miss_ready_o,
    input  logic [ADDR_W-1:0] miss_addr_i,
    input  logic              miss_way_i,
    input  logic              miss_dirty_i,
    input  logic [TAG_W-1:0]  miss_victim_tag_i,
    output logic              miss_done_o,
    output logic              wb_ena_o,
    output logic [ADDR_W-1:0] wb_addr_o,
    output logic              wb_way_o,
    input  logic [LINE_W-1:0] wb_line_i,
    output logic              refill_we_o,
    output logic              refill_way_o,
    output logic [ADDR_W-1:0] refill_addr_o,
    output logic [LINE_W-1:0] refill_line_o,
    output logic              mem_req_valid_o,
    input  logic              mem_req_ready_i,
    output logic              mem_req_we_o,
    output logic [ADDR_W-1:0] mem_req_addr_o,
    output logic [CNT_W-1:0]  mem_req_len_o,
    output logic              mem_wvalid_o,
    input  logic              mem_wready_i,
    output logic [BEAT_W-1:0] mem_wdata_o,
    output logic              mem_wlast_o,
    input  logic              mem_rvalid_i,
    input  logic [BEAT_W-1:0] mem_rdata_i,
    input  logic              mem_rlast_i,
    output logic              proto_err_o
`ifdef DCACHE_MISS_STATS_EN
    ,
    output logic [31:0]       stat_miss_o,
    output logic [31:0]       stat_wb_o
`endif
);

    miss_state_e       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              way_q, way_d;
    logic              dirty_q, dirty_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic              proto_err_q, proto_err_d;

    logic              accept;
    logic              buf_load, buf_beat_wr, buf_beat_rd;
    logic [BEAT_W-1:0] buf_beat;
    logic [CNT_W-1:0]  buf_cnt;
    logic [LINE_W-1:0] buf_line;

    assign accept = (state_q == S_IDLE) && miss_valid_i;

    dcache_line_buf u_line_buf (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .load_i    (buf_load),
        .line_i    (wb_line_i),
        .beat_wr_i (buf_beat_wr),
        .beat_i    (mem_rdata_i),
        .beat_rd_i (buf_beat_rd),
        .beat_o    (buf_beat),
        .cnt_o     (buf_cnt),
        .line_o    (buf_line)
    );

    // Outputs are decoded from the state alone, so they hold steady while a handshake stalls.
    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        way_d           = way_q;
        dirty_d         = dirty_q;
        tag_d           = tag_q;
        proto_err_d     = proto_err_q;
        miss_ready_o    = 1'b0;
        miss_done_o     = 1'b0;
        wb_ena_o        = 1'b0;
        wb_addr_o       = '0;
        wb_way_o        = 1'b0;
        refill_we_o     = 1'b0;
        refill_way_o    = 1'b0;
        refill_addr_o   = '0;
        refill_line_o   = '0;
        mem_req_valid_o = 1'b0;
        mem_req_we_o    = 1'b0;
        mem_req_addr_o  = '0;
        mem_req_len_o   = '0;
        mem_wvalid_o    = 1'b0;
        mem_wdata_o     = '0;
        mem_wlast_o     = 1'b0;
        buf_load        = 1'b0;
        buf_beat_wr     = 1'b0;
        buf_beat_rd     = 1'b0;

        case (state_q)
            S_IDLE: begin
                miss_ready_o = 1'b1;
                if (accept) begin
                    addr_d  = miss_addr_i;
                    way_d   = miss_way_i;
                    dirty_d = miss_dirty_i;
                    tag_d   = miss_victim_tag_i;
                    state_d = miss_dirty_i ? S_WB_RD : S_RD_REQ;
                end
            end
            S_WB_RD: begin
                wb_ena_o  = 1'b1;
                wb_addr_o = wb_base(tag_q, addr_q[OFFSET_W +: INDEX_W]);
                wb_way_o  = way_q;
                state_d   = S_WB_CAP;
            end
            S_WB_CAP: begin
                buf_load = 1'b1;
                state_d  = S_WB_REQ;
            end
            S_WB_REQ: begin
                mem_req_valid_o = 1'b1;
                mem_req_we_o    = 1'b1;
                mem_req_addr_o  = wb_base(tag_q, addr_q[OFFSET_W +: INDEX_W]);
                mem_req_len_o   = LAST_BEAT;
                if (mem_req_ready_i) begin
                    state_d = S_WB_DATA;
                end
            end
            S_WB_DATA: begin
                mem_wvalid_o = 1'b1;
                mem_wdata_o  = buf_beat;
                mem_wlast_o  = (buf_cnt == LAST_BEAT);
                if (mem_wready_i) begin
                    buf_beat_rd = 1'b1;
                    if (buf_cnt == LAST_BEAT) begin
                        state_d = S_RD_REQ;
                    end
                end
            end
            S_RD_REQ: begin
                mem_req_valid_o = 1'b1;
                mem_req_addr_o  = line_base(addr_q);
                mem_req_len_o   = LAST_BEAT;
                if (mem_req_ready_i) begin
                    state_d = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                // The beat count alone ends the burst; a misplaced rlast is only flagged.
                if (mem_rvalid_i) begin
                    buf_beat_wr = 1'b1;
                    if (mem_rlast_i != (buf_cnt == LAST_BEAT)) begin
                        proto_err_d = 1'b1;
                    end
                    if (buf_cnt == LAST_BEAT) begin
                        state_d = S_REFILL;
                    end
                end
            end
            S_REFILL: begin
                refill_we_o   = 1'b1;
                refill_way_o  = way_q;
                refill_addr_o = line_base(addr_q);
                refill_line_o = buf_line;
                state_d       = S_DONE;
            end
            S_DONE: begin
                miss_done_o = 1'b1;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            way_q       <= 1'b0;
            dirty_q     <= 1'b0;
            tag_q       <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            way_q       <= way_d;
            dirty_q     <= dirty_d;
            tag_q       <= tag_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign proto_err_o = proto_err_q;

`ifdef DCACHE_MISS_STATS_EN
    logic [31:0] stat_miss_q, stat_wb_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stat_miss_q <= '0;
            stat_wb_q   <= '0;
        end else begin
            if (accept) begin
                stat_miss_q <= stat_miss_q + 32'd1;
            end
            if ((state_d == S_WB_RD) && (state_q != S_WB_RD)) begin
                stat_wb_q <= stat_wb_q + 32'd1;
            end
        end
    end

    assign stat_miss_o = stat_miss_q;
    assign stat_wb_o   = stat_wb_q;
`endif

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// Self-checking bench for dcache_miss_ctrl with behavioural cache/memory models.
// Statistics checks are compiled in when DCACHE_MISS_STATS_EN is defined.
module tb_dcache_miss_ctrl;
    import dcache_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         miss_valid, miss_ready, miss_way, miss_dirty, miss_done;
    logic [31:0]  miss_addr;
    logic [19:0]  miss_victim_tag;
    logic         wb_ena, wb_way;
    logic [31:0]  wb_addr;
    logic [127:0] wb_line;
    logic         refill_we, refill_way;
    logic [31:0]  refill_addr;
    logic [127:0] refill_line;
    logic         mem_req_valid, mem_req_ready, mem_req_we;
    logic [31:0]  mem_req_addr;
    logic [1:0]   mem_req_len;
    logic         mem_wvalid, mem_wready, mem_wlast;
    logic [31:0]  mem_wdata;
    logic         mem_rvalid, mem_rlast;
    logic [31:0]  mem_rdata;
    logic         proto_err;
`ifdef DCACHE_MISS_STATS_EN
    logic [31:0]  stat_miss, stat_wb;
`endif

    int checks   = 0;
    int failed   = 0;
    int rel      = 0;
    bit expPerr  = 1'b0;
    int statMiss = 0;
    int statWb   = 0;

    always #5 clk = ~clk;

    dcache_miss_ctrl dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .miss_valid_i      (miss_valid),
        .miss_ready_o      (miss_ready),
        .miss_addr_i       (miss_addr),
        .miss_way_i        (miss_way),
        .miss_dirty_i      (miss_dirty),
        .miss_victim_tag_i (miss_victim_tag),
        .miss_done_o       (miss_done),
        .wb_ena_o          (wb_ena),
        .wb_addr_o         (wb_addr),
        .wb_way_o          (wb_way),
        .wb_line_i         (wb_line),
        .refill_we_o       (refill_we),
        .refill_way_o      (refill_way),
        .refill_addr_o     (refill_addr),
        .refill_line_o     (refill_line),
        .mem_req_valid_o   (mem_req_valid),
        .mem_req_ready_i   (mem_req_ready),
        .mem_req_we_o      (mem_req_we),
        .mem_req_addr_o    (mem_req_addr),
        .mem_req_len_o     (mem_req_len),
        .mem_wvalid_o      (mem_wvalid),
        .mem_wready_i      (mem_wready),
        .mem_wdata_o       (mem_wdata),
        .mem_wlast_o       (mem_wlast),
        .mem_rvalid_i      (mem_rvalid),
        .mem_rdata_i       (mem_rdata),
        .mem_rlast_i       (mem_rlast),
        .proto_err_o       (proto_err)
`ifdef DCACHE_MISS_STATS_EN
        ,
        .stat_miss_o       (stat_miss),
        .stat_wb_o         (stat_wb)
`endif
    );

    // Advance one cycle and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        rel++;
    endtask

    task automatic checkOutput(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_ready"}, 160'(miss_ready), 160'(1));
        checkOutput({tag, "_ctrl"},
                    160'({miss_done, wb_ena, wb_addr, wb_way, refill_we, refill_way, refill_addr,
                          mem_req_valid, mem_req_we, mem_req_addr, mem_req_len,
                          mem_wvalid, mem_wdata, mem_wlast, proto_err}), 160'(0));
        checkOutput({tag, "_refill_line"}, 160'(refill_line), 160'(0));
`ifdef DCACHE_MISS_STATS_EN
        checkOutput({tag, "_stat_miss"}, 160'(stat_miss), 160'(0));
        checkOutput({tag, "_stat_wb"}, 160'(stat_wb), 160'(0));
`endif
    endtask

    // Drive one miss, play cache and memory, and compare the observed transaction to the expected one.
    // mode 0: zero-wait memory; mode 1: request stalls, random wready, rvalid gaps and stray rvalid.
    task automatic applyStimulus(input logic [31:0] addr, input logic way, input logic dirty,
                                 input logic [19:0] tag, input logic [127:0] victim,
                                 input logic [127:0] rline, input int mode, input bit holdValid,
                                 input int rlastBeat, input int abortAfter);
        logic [31:0] expBase, expWbBase, wbAddrS, refAddr, stAddr, stWd;
        logic [127:0] refLine;
        logic [32:0] reqQ[$];
        logic [32:0] wQ[$];
        logic [31:0] rdQ[$];
        logic [32:0] e;
        logic wbWayS, refWay, stWe, stWl, wbPrev, reqStall, wStall;
        int wbCnt, wbCyc, refCnt, refCyc, doneCnt, doneCyc, busyReady, stab, lenErr, beatsSent, reqWait;
        bit aborted;

        expBase   = {addr[31:4], 4'h0};
        expWbBase = {tag, addr[11:4], 4'h0};
        wbCnt = 0; wbCyc = 0; refCnt = 0; refCyc = 0; doneCnt = 0; doneCyc = 0;
        busyReady = 0; stab = 0; lenErr = 0; beatsSent = 0; reqWait = 0; aborted = 1'b0;
        wbPrev = 1'b0; reqStall = 1'b0; wStall = 1'b0;
        stAddr = '0; stWd = '0; stWe = 1'b0; stWl = 1'b0;
        wbAddrS = '0; wbWayS = 1'b0; refLine = '0; refWay = 1'b0; refAddr = '0;

        checkOutput("ready_in_idle", 160'(miss_ready), 160'(1));
        miss_valid      = 1'b1;
        miss_addr       = addr;
        miss_way        = way;
        miss_dirty      = dirty;
        miss_victim_tag = tag;
        statMiss++;
        if (dirty) statWb++;
        rel = 0;

        for (int g = 0; g < 400 && doneCnt == 0 && !aborted; g++) begin
            tick();
            if (!holdValid) begin
                miss_valid      = 1'($urandom_range(0, 1));
                miss_addr       = $urandom;
                miss_way        = 1'($urandom_range(0, 1));
                miss_dirty      = 1'($urandom_range(0, 1));
                miss_victim_tag = 20'($urandom);
            end
            if (miss_ready) busyReady++;
            if (reqStall && !(mem_req_valid && mem_req_addr == stAddr && mem_req_we == stWe)) stab++;
            if (wStall && !(mem_wvalid && mem_wdata == stWd && mem_wlast == stWl)) stab++;
            if (mem_req_valid && mem_req_len != 2'd3) lenErr++;
            if (wb_ena) begin
                wbCnt++; wbCyc = rel; wbAddrS = wb_addr; wbWayS = wb_way;
            end
            if (refill_we) begin
                refCnt++; refCyc = rel; refLine = refill_line; refWay = refill_way; refAddr = refill_addr;
            end
            if (miss_done) begin
                doneCnt++; doneCyc = rel;
            end

            // The cache returns the victim line one cycle after the read strobe; junk otherwise.
            wb_line = wbPrev ? victim : {$urandom, $urandom, $urandom, $urandom};
            wbPrev  = wb_ena;

            if (abortAfter >= 0 && beatsSent == abortAfter) begin
                mem_rvalid = 1'b0;
                rst = 1'b1;
                tick();
                checkResetState("abort");
                checkOutput("abort_no_refill", 160'(refCnt), 160'(0));
                rst = 1'b0;
                expPerr  = 1'b0;
                statMiss = 0;
                statWb   = 0;
                aborted  = 1'b1;
            end else begin
                if (rdQ.size() > 0 && (mode == 0 || $urandom_range(0, 1) == 1)) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = rdQ.pop_front();
                    mem_rlast  = (beatsSent == rlastBeat);
                    beatsSent++;
                end else if (rdQ.size() == 0 && mode == 1 && $urandom_range(0, 3) == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = $urandom;
                    mem_rlast  = 1'($urandom_range(0, 1));
                end else begin
                    mem_rvalid = 1'b0;
                    mem_rdata  = $urandom;
                    mem_rlast  = 1'b0;
                end

                if (mem_req_valid) begin
                    reqWait       = reqStall ? reqWait + 1 : 0;
                    mem_req_ready = (mode == 0) || (reqWait >= 3);
                    if (mem_req_ready) begin
                        reqQ.push_back({mem_req_we, mem_req_addr});
                        if (!mem_req_we) begin
                            for (int k = 0; k < 4; k++) rdQ.push_back(rline[32*k +: 32]);
                        end
                        reqStall = 1'b0;
                    end else begin
                        reqStall = 1'b1; stAddr = mem_req_addr; stWe = mem_req_we;
                    end
                end else begin
                    mem_req_ready = 1'($urandom_range(0, 1));
                    reqStall = 1'b0;
                    reqWait  = 0;
                end

                if (mem_wvalid) begin
                    mem_wready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
                    if (mem_wready) begin
                        wQ.push_back({mem_wlast, mem_wdata});
                        wStall = 1'b0;
                    end else begin
                        wStall = 1'b1; stWd = mem_wdata; stWl = mem_wlast;
                    end
                end else begin
                    mem_wready = 1'($urandom_range(0, 1));
                    wStall = 1'b0;
                end
            end
        end

        if (!aborted) begin
            if (rlastBeat != 3) expPerr = 1'b1;
            checkOutput("miss_done_seen", 160'(doneCnt), 160'(1));
            checkOutput("refill_once", 160'(refCnt), 160'(1));
            checkOutput("refill_line", 160'(refLine), 160'(rline));
            checkOutput("refill_way", 160'(refWay), 160'(way));
            checkOutput("refill_addr", 160'(refAddr), 160'(expBase));
            checkOutput("done_after_refill", 160'(doneCyc), 160'(refCyc + 1));
            if (mode == 0) checkOutput("done_latency", 160'(doneCyc), 160'(dirty ? 14 : 7));
            checkOutput("busy_not_ready", 160'(busyReady), 160'(0));
            checkOutput("held_stable", 160'(stab), 160'(0));
            checkOutput("req_len", 160'(lenErr), 160'(0));
            checkOutput("proto_err", 160'(proto_err), 160'(expPerr));
            checkOutput("wb_count", 160'(wbCnt), 160'(dirty));
            checkOutput("req_count", 160'(reqQ.size()), 160'(dirty ? 2 : 1));
            if (dirty) begin
                checkOutput("wb_addr", 160'(wbAddrS), 160'(expWbBase));
                checkOutput("wb_way", 160'(wbWayS), 160'(way));
                checkOutput("wb_cycle", 160'(wbCyc), 160'(1));
                e = (reqQ.size() > 0) ? reqQ[0] : '1;
                checkOutput("wr_req", 160'(e), 160'({1'b1, expWbBase}));
                e = (reqQ.size() > 1) ? reqQ[1] : '1;
                checkOutput("rd_req", 160'(e), 160'({1'b0, expBase}));
                checkOutput("wbeat_count", 160'(wQ.size()), 160'(4));
                for (int k = 0; k < 4; k++) begin
                    e = (k < wQ.size()) ? wQ[k] : '1;
                    checkOutput($sformatf("wbeat%0d", k), 160'(e), 160'({k == 3, victim[32*k +: 32]}));
                end
            end else begin
                e = (reqQ.size() > 0) ? reqQ[0] : '1;
                checkOutput("rd_req", 160'(e), 160'({1'b0, expBase}));
                checkOutput("wbeat_count", 160'(wQ.size()), 160'(0));
            end
`ifdef DCACHE_MISS_STATS_EN
            checkOutput("stat_miss", 160'(stat_miss), 160'(statMiss));
            checkOutput("stat_wb", 160'(stat_wb), 160'(statWb));
`endif
            tick();
        end
        if (!holdValid) miss_valid = 1'b0;
        mem_rvalid = 1'b0;
    endtask

    initial begin
        logic [127:0] v, r;

        rst = 1'b1;
        miss_valid = 1'b0; miss_addr = '0; miss_way = 1'b0; miss_dirty = 1'b0; miss_victim_tag = '0;
        wb_line = '0; mem_req_ready = 1'b0; mem_wready = 1'b0;
        mem_rvalid = 1'b0; mem_rdata = '0; mem_rlast = 1'b0;
        tick();
        tick();
        checkResetState("reset");
        rst = 1'b0;

        $display("[TB] clean miss, zero-wait memory");
        applyStimulus(32'h0000_1234, 1'b1, 1'b0, 20'h0ABCD, '0,
                      128'h000000A3_000000A2_000000A1_000000A0, 0, 1'b0, 3, -1);

        $display("[TB] dirty miss with writeback");
        applyStimulus(32'h0000_2040, 1'b0, 1'b1, 20'h00005,
                      128'h44444444_33333333_22222222_11111111,
                      {$urandom, $urandom, $urandom, $urandom}, 0, 1'b0, 3, -1);

        $display("[TB] dirty miss under backpressure");
        applyStimulus($urandom, 1'b1, 1'b1, 20'($urandom), {$urandom, $urandom, $urandom, $urandom},
                      {$urandom, $urandom, $urandom, $urandom}, 1, 1'b0, 3, -1);

        $display("[TB] miss_valid held high across back-to-back misses");
        r = {$urandom, $urandom, $urandom, $urandom};
        applyStimulus(32'h0000_7788, 1'b0, 1'b0, 20'h12345, '0, r, 0, 1'b1, 3, -1);
        applyStimulus(32'h0000_7788, 1'b0, 1'b0, 20'h12345, '0, r, 0, 1'b0, 3, -1);

        $display("[TB] reset during read burst, recovery and rlast error");
        applyStimulus(32'h0000_3300, 1'b1, 1'b0, 20'h00001, '0,
                      {$urandom, $urandom, $urandom, $urandom}, 0, 1'b0, 3, 2);
        applyStimulus(32'h0000_4410, 1'b1, 1'b0, 20'h00002, '0,
                      {$urandom, $urandom, $urandom, $urandom}, 0, 1'b0, 3, -1);
        applyStimulus(32'h0000_5520, 1'b0, 1'b0, 20'h00003, '0,
                      {$urandom, $urandom, $urandom, $urandom}, 0, 1'b0, 1, -1);
        applyStimulus(32'h0000_6630, 1'b1, 1'b1, 20'h00004, {$urandom, $urandom, $urandom, $urandom},
                      {$urandom, $urandom, $urandom, $urandom}, 1, 1'b0, 3, -1);

        $display("[TB] randomized misses");
        for (int i = 0; i < 12; i++) begin
            v = {$urandom, $urandom, $urandom, $urandom};
            r = {$urandom, $urandom, $urandom, $urandom};
            applyStimulus($urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 20'($urandom),
                          v, r, int'($urandom_range(0, 1)), 1'b0, 3, -1);
        end

        $display("%0d/%0d checks passed", checks - failed, checks);
        $finish;
    end

endmodule
